water_tank_controller: RTL and testbench
========================================

WATER_TANK_CONTROLLER -- requirements
Module: water_tank_controller

Interface
REQ-001 SHALL have one clock, clk, and reset rst_n, which is asynchronous and active-low.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: cycles a synchronized sensor must stay stable before it is accepted (min 1).
REQ-003 Parameter FILL_TIMEOUT, default 1000: maximum cycles spent in FILL before a fault (min 2).
REQ-004 clk  input  1  system clock; every flop is rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 low_sensor  input  1  raw float switch, asynchronous; 1 = water at or above the low mark.
REQ-007 high_sensor  input  1  raw float switch, asynchronous; 1 = water at or above the high mark.
REQ-008 fault_clear  input  1  synchronous single-cycle fault acknowledge.
REQ-009 water_box  output  2  registered tank level to the irrigation block: 00 empty, 10 medium, 11 full, 01 never driven.
REQ-010 pump  output  1  registered fill-pump enable.
REQ-011 fault  output  1  registered fault flag.

Function
REQ-012 Each sensor SHALL pass through a 2-flop synchronizer.
- Each sensor then SHALL pass through its own debounce counter.
- The counter clears whenever the synchronized value differs from the last accepted value.
- The new value is accepted after DEBOUNCE_CYCLES consecutive differing samples.
REQ-013 Debounced (low, high) SHALL decode as follows.
- (0,0) = empty; (1,0) = medium; (1,1) = full.
- (0,1) = implausible.
REQ-014 water_box SHALL update exactly 1 cycle after a debounced value changes.
- It SHALL be 00 whenever the decoded level is implausible or the FSM is in FAULT.
REQ-015 A raw sensor change held stable SHALL appear on water_box within 2 + DEBOUNCE_CYCLES + 1 cycles.
- A raw pulse shorter than DEBOUNCE_CYCLES cycles SHALL never change water_box.
REQ-016 The FSM SHALL have states IDLE, FILL and FAULT.
- pump = 1 only in FILL.
- fault = 1 only in FAULT.
- Both outputs are registered (Moore).
REQ-017 IDLE transitions:
- to FILL when the level is empty and the ready flag (REQ-023) is set;
- to FAULT when the level is implausible;
- otherwise IDLE.
REQ-018 FILL transitions:
- to IDLE when the level is full;
- to FAULT when the level is implausible or on timeout (REQ-026);
- medium keeps FILL (hysteresis).
REQ-019 FAULT SHALL exit to IDLE only when fault_clear = 1 and the level is plausible.
- Otherwise fault_clear SHALL be ignored and the FSM stays in FAULT.
REQ-020 The fill timeout counter SHALL clear on every entry to FILL and increment each FILL cycle.
- When the count reaches FILL_TIMEOUT-1, the FSM SHALL move to FAULT on the next edge.
REQ-021 If full and timeout occur in the same cycle, full SHALL win (transition to IDLE).
- If implausible and full occur in the same cycle, implausible SHALL win.
REQ-022 A transition from medium down to empty while in IDLE SHALL start FILL.
- A drop from full to medium SHALL NOT start FILL.

Reset
REQ-023 While rst_n = 0, the block SHALL hold the following:
- water_box = 00, pump = 0, fault = 0;
- state = IDLE;
- synchronizer, debounce, accepted and timeout registers all 0;
- ready flag = 0.
REQ-024 After reset release, the ready flag SHALL set once both sensors have completed their first full debounce window.
- pump SHALL stay 0 until then.
REQ-025 Asserting rst_n mid-FILL SHALL drop pump to 0 immediately, without waiting for clk.

Configuration
REQ-026 Macro WATER_TANK_TIMEOUT_EN controls the fill timeout.
- Defined: the timeout counter and the FILL->FAULT timeout path exist.
- Undefined: no timeout counter is synthesized; FILL exits only on full or implausible; FILL_TIMEOUT is ignored.

Verification (DEBOUNCE_CYCLES=4, FILL_TIMEOUT=50, macro defined unless stated)
REQ-027 Release reset with low=0, high=0:
- water_box = 00 throughout;
- pump = 1 within 8 cycles;
- fault = 0.
REQ-028 In FILL, set low=1:
- water_box -> 10 within 7 cycles, pump stays 1.
Then set high=1:
- water_box -> 11 and pump -> 0.
Then drop high to 0:
- water_box -> 10, pump stays 0.
REQ-029 In IDLE/medium, pulse high=1 for 2 cycles:
- water_box stays 10, pump stays 0, fault stays 0.
REQ-030 Hold low=0, high=0 in FILL:
- fault = 1 and pump = 0 exactly 51 cycles after FILL entry.
Then pulse fault_clear:
- IDLE, then FILL again next cycle.
Repeat with the macro undefined:
- pump stays 1 indefinitely.
REQ-031 Drive low=0, high=1:
- fault = 1, water_box = 00, pump = 0.
Pulse fault_clear while still implausible:
- fault stays 1.
Set low=1, then pulse fault_clear:
- fault = 0, water_box = 11.
REQ-032 Assert rst_n = 0 mid-FILL between clock edges:
- pump = 0 before the next edge;
- after release, the REQ-027 sequence repeats.

Source files
------------

// File: rtl/water_tank_controller_if.sv
// Tank sensor/actuator bundle shared by the level controller and its environment.
// master: the plant side (drives sensors and the fault acknowledge).
// slave : the controller side (drives level, pump and fault).
interface water_tank_controller_if;
  logic       low_sensor;
  logic       high_sensor;
  logic       fault_clear;
  logic [1:0] water_box;
  logic       pump;
  logic       fault;

  modport master (
    output low_sensor, high_sensor, fault_clear,
    input  water_box, pump, fault
  );

  modport slave (
    input  low_sensor, high_sensor, fault_clear,
    output water_box, pump, fault
  );
endinterface

// File: rtl/water_tank_controller.sv
// Water tank level controller.
// Synchronizes and debounces the low/high float switches, decodes the tank
// level, and runs an IDLE/FILL/FAULT pump FSM with registered outputs.
// Optional feature: define WATER_TANK_TIMEOUT_EN to add the fill timeout
// (FILL lasting too long raises a fault). Without it FILL_TIMEOUT is unused.
module water_tank_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FILL_TIMEOUT    = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  water_tank_controller_if.slave  tank
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = $clog2(DEBOUNCE_CYCLES + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // bit 0 = low switch, bit 1 = high switch
  logic [1:0] sensor_raw;
  logic [1:0] sensor_db;

  assign sensor_raw = {tank.high_sensor, tank.low_sensor};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
    logic            sync1_reg;
    logic            sync2_reg;
    logic            accepted_reg;
    logic [DB_W-1:0] db_cnt_reg;

    // Two-flop synchronizer, then accept a new value only after it has
    // differed from the accepted one for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg    <= 1'b0;
        sync2_reg    <= 1'b0;
        accepted_reg <= 1'b0;
        db_cnt_reg   <= '0;
      end else begin
        sync1_reg <= sensor_raw[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg != accepted_reg) begin
          if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            accepted_reg <= sync2_reg;
            db_cnt_reg   <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end else begin
          db_cnt_reg <= '0;
        end
      end
    end

    assign sensor_db[gi] = accepted_reg;
  end

  // Ready once the synchronizers have filled and one full debounce window of
  // samples has been taken from both sensors; until then the level is unproven.
  logic [ST_W-1:0] start_cnt_reg;
  logic            ready_reg;

  // Startup window counter and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt_reg <= '0;
      ready_reg     <= 1'b0;
    end else if (!ready_reg) begin
      if (start_cnt_reg == ST_W'(DEBOUNCE_CYCLES + 1)) begin
        ready_reg <= 1'b1;
      end else begin
        start_cnt_reg <= start_cnt_reg + 1'b1;
      end
    end
  end

  logic level_empty;
  logic level_full;
  logic level_bad;

  assign level_empty = !sensor_db[0] && !sensor_db[1];
  assign level_full  =  sensor_db[0] &&  sensor_db[1];
  assign level_bad   = !sensor_db[0] &&  sensor_db[1];

  state_t state_reg;
  state_t state_next;
  logic   fill_timeout;

`ifdef WATER_TANK_TIMEOUT_EN
  localparam int TMO_W = $clog2(FILL_TIMEOUT);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             fill_first_reg;

  // Fill timeout: cleared in the first FILL cycle, then counts FILL cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg    <= '0;
      fill_first_reg <= 1'b0;
    end else begin
      fill_first_reg <= (state_next == ST_FILL) && (state_reg != ST_FILL);
      if ((state_reg != ST_FILL) || fill_first_reg) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end

  assign fill_timeout = (state_reg == ST_FILL) &&
                        (tmo_cnt_reg == TMO_W'(FILL_TIMEOUT - 1));
`else
  assign fill_timeout = 1'b0;
`endif

  // Next-state logic; within FILL implausible beats full, full beats timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (level_bad) begin
          state_next = ST_FAULT;
        end else if (level_empty && ready_reg) begin
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (level_bad) begin
          state_next = ST_FAULT;
        end else if (level_full) begin
          state_next = ST_IDLE;
        end else if (fill_timeout) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (tank.fault_clear && !level_bad) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic [1:0] water_box_reg;
  logic       pump_reg;
  logic       fault_reg;

  // State register plus Moore outputs registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      water_box_reg <= 2'b00;
      pump_reg      <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pump_reg  <= (state_next == ST_FILL);
      fault_reg <= (state_next == ST_FAULT);
      if (level_bad || (state_next == ST_FAULT)) begin
        water_box_reg <= 2'b00;
      end else begin
        // empty -> 00, medium -> 10, full -> 11
        water_box_reg <= {sensor_db[0], sensor_db[1]};
      end
    end
  end

  assign tank.water_box = water_box_reg;
  assign tank.pump      = pump_reg;
  assign tank.fault     = fault_reg;

endmodule

// File: tb/tb_water_tank_controller.sv
// Directed bench for water_tank_controller (DEBOUNCE_CYCLES=4, FILL_TIMEOUT=50).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_water_tank_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  water_tank_controller_if tank_if ();

  water_tank_controller #(
    .DEBOUNCE_CYCLES (4),
    .FILL_TIMEOUT    (50)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tank  (tank_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int sig_val(input int sel);
    case (sel)
      0:       return int'(tank_if.water_box);
      1:       return int'(tank_if.pump);
      default: return int'(tank_if.fault);
    endcase
  endfunction

  // Ticks until the selected output (0 box, 1 pump, 2 fault) equals val;
  // n is the tick count, or -1 if the budget ran out.
  task automatic wait_sig(input int sel, input int val, input int max_ticks, output int n);
    n = -1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (sig_val(sel) == val) begin
        n = i;
        break;
      end
    end
  endtask

  // Called with rst_n low and both sensors at 0; releases reset and expects
  // the pump to start once the sensors are proven empty.
  task automatic startup(input string tag);
    int first;
    tick();
    check_value({tag, "_rst_box"},   int'(tank_if.water_box), 0);
    check_value({tag, "_rst_pump"},  int'(tank_if.pump), 0);
    check_value({tag, "_rst_fault"}, int'(tank_if.fault), 0);
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_value({tag, "_box_empty"}, int'(tank_if.water_box), 0);
      check_value({tag, "_no_fault"},  int'(tank_if.fault), 0);
      if (i <= 5) check_value({tag, "_pump_not_ready"}, int'(tank_if.pump), 0);
      if (tank_if.pump) begin
        first = i;
        break;
      end
    end
    check_value({tag, "_pump_within_8"}, int'(first >= 1 && first <= 8), 1);
  endtask

  task automatic pulse_clear();
    tank_if.fault_clear = 1'b1;
    tick();
    tank_if.fault_clear = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    tank_if.low_sensor  = 1'b0;
    tank_if.high_sensor = 1'b0;
    tank_if.fault_clear = 1'b0;
    tick();
    tick();

    // Startup with an empty tank
    startup("boot");

`ifdef WATER_TANK_TIMEOUT_EN
    // Empty tank never fills: timeout fault 51 cycles after FILL entry
    wait_sig(2, 1, 60, n);
    check_value("timeout_cycles", n, 51);
    check_value("timeout_pump",   int'(tank_if.pump), 0);
    check_value("timeout_box",    int'(tank_if.water_box), 0);
    pulse_clear();
    check_value("clear_fault", int'(tank_if.fault), 0);
    check_value("clear_idle_pump", int'(tank_if.pump), 0);
    tick();
    check_value("refill_pump", int'(tank_if.pump), 1);
`else
    // Without the timeout the pump keeps running
    for (int i = 0; i < 80; i++) tick();
    check_value("no_timeout_pump",  int'(tank_if.pump), 1);
    check_value("no_timeout_fault", int'(tank_if.fault), 0);
`endif

    // Rising water: medium keeps filling, full stops the pump
    tank_if.low_sensor = 1'b1;
    wait_sig(0, 2, 7, n);
    check_value("medium_within_7", int'(n > 0), 1);
    check_value("medium_pump", int'(tank_if.pump), 1);
    tank_if.high_sensor = 1'b1;
    wait_sig(0, 3, 8, n);
    check_value("full_box_seen", int'(n > 0), 1);
    check_value("full_pump_off", int'(tank_if.pump), 0);
    tank_if.high_sensor = 1'b0;
    wait_sig(0, 2, 8, n);
    check_value("drop_medium_seen", int'(n > 0), 1);
    for (int i = 0; i < 4; i++) tick();
    check_value("drop_medium_pump", int'(tank_if.pump), 0);

    // Short glitch on the high switch is filtered
    tank_if.high_sensor = 1'b1;
    tick();
    tick();
    tank_if.high_sensor = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_value("glitch_box", int'(tank_if.water_box), 2);
    end
    check_value("glitch_pump",  int'(tank_if.pump), 0);
    check_value("glitch_fault", int'(tank_if.fault), 0);

    // Medium down to empty in IDLE restarts filling
    tank_if.low_sensor = 1'b0;
    wait_sig(1, 1, 10, n);
    check_value("empty_refill", int'(n > 0), 1);
    check_value("empty_box", int'(tank_if.water_box), 0);

    // Implausible sensors (low=0, high=1) fault out of FILL
    tank_if.high_sensor = 1'b1;
    wait_sig(2, 1, 10, n);
    check_value("bad_fault_seen", int'(n > 0), 1);
    check_value("bad_box",  int'(tank_if.water_box), 0);
    check_value("bad_pump", int'(tank_if.pump), 0);
    pulse_clear();
    check_value("bad_clear_ignored", int'(tank_if.fault), 1);
    tick();
    check_value("bad_clear_hold", int'(tank_if.fault), 1);
    tank_if.low_sensor = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check_value("full_in_fault", int'(tank_if.fault), 1);
    check_value("full_in_fault_box", int'(tank_if.water_box), 0);
    pulse_clear();
    check_value("good_clear_fault", int'(tank_if.fault), 0);
    check_value("good_clear_box",   int'(tank_if.water_box), 3);
    check_value("good_clear_pump",  int'(tank_if.pump), 0);

    // Drain to empty, then reset asynchronously in the middle of FILL
    tank_if.low_sensor  = 1'b0;
    tank_if.high_sensor = 1'b0;
    wait_sig(1, 1, 10, n);
    check_value("drain_fill", int'(n > 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_rst_pump",  int'(tank_if.pump), 0);
    check_value("async_rst_box",   int'(tank_if.water_box), 0);
    check_value("async_rst_fault", int'(tank_if.fault), 0);
    startup("reboot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
